instr_sequencer: RTL and testbench



---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/instr_decoder.sv | 48 ++++
 rtl/instr_sequencer.sv | 132 +++++++++++++
 tb/tb_instr_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the instruction sequencer: opcodes, FSM states, control word.
// STEP_WAIT exists only when SINGLE_STEP_EN is defined.
package cpu_pkg;

    localparam int PC_W_DEFAULT   = 4;
    localparam int INST_W_DEFAULT = 16;

    typedef enum logic [3:0] {
        OP_LOAD  = 4'b0000,
        OP_STORE = 4'b0001,
        OP_ADD   = 4'b0010,
        OP_SUB   = 4'b0011,
        OP_LI    = 4'b0100,
        OP_BEQ   = 4'b0101,
        OP_HALT  = 4'b1111
    } opcode_t;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        DECODE    = 3'd2,
        EXECUTE   = 3'd3,
        MEMORY    = 3'd4,
        WRITEBACK = 3'd5,
`ifdef SINGLE_STEP_EN
        STEP_WAIT = 3'd6,
`endif
        HALT      = 3'd7
    } state_t;

    typedef struct packed {
        logic w1;
        logic w2;
        logic w3;
        logic alu_ctl;
        logic branch;
        logic mem_to_reg;
        logic memo;
        logic reg_wr;
        logic mem_wr;
        logic mem_op;
        logic halt;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decode into the datapath control word plus illegal flag.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl,
    output logic       illegal
);

    always_comb begin
        ctrl    = CTRL_NOP;
        illegal = 1'b0;
        case (opcode)
            OP_LOAD: begin
                ctrl.w1         = 1'b1;
                ctrl.w3         = 1'b1;
                ctrl.memo       = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_wr     = 1'b1;
                ctrl.mem_op     = 1'b1;
            end
            OP_STORE: begin
                ctrl.w3     = 1'b1;
                ctrl.memo   = 1'b1;
                ctrl.mem_wr = 1'b1;
                ctrl.mem_op = 1'b1;
            end
            OP_ADD: begin
                ctrl.w1     = 1'b1;
                ctrl.reg_wr = 1'b1;
            end
            OP_SUB: begin
                ctrl.w1      = 1'b1;
                ctrl.alu_ctl = 1'b1;
                ctrl.reg_wr  = 1'b1;
            end
            OP_LI: begin
                ctrl.w1     = 1'b1;
                ctrl.w2     = 1'b1;
                ctrl.reg_wr = 1'b1;
            end
            OP_BEQ:  ctrl.branch = 1'b1;
            OP_HALT: ctrl.halt   = 1'b1;
            default: illegal     = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetch/decode/execute/memory/writeback control.
// Define SINGLE_STEP_EN to park in STEP_WAIT after each instruction until step=1.
//
// state     | meaning
// IDLE      | waiting for start
// FETCH     | imem_addr = pc, IR captured on exit
// DECODE    | IR decoded, selects driven
// EXECUTE   | zero flag sampled on exit
// MEMORY    | LOAD/STORE only, memWE for STORE
// WRITEBACK | regWE for LI/ADD/SUB/LOAD, pc updated on exit
// STEP_WAIT | (SINGLE_STEP_EN) waits for step
// HALT      | terminal until reset
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W   = PC_W_DEFAULT,
    parameter int INST_W = INST_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              step,
    input  logic              zero,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [PC_W-1:0]   imem_addr,
    output logic [INST_W-1:0] RDinst,
    output logic              W1,
    output logic              W2,
    output logic              W3,
    output logic              ALUCONTROL,
    output logic              Branch,
    output logic              MemToReg,
    output logic              memo,
    output logic              regWE,
    output logic              memWE,
    output logic              busy,
    output logic              halted,
    output logic              illegal
);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] ir;
    logic              zero_q;
    logic              illegal_q;
    ctrl_t             ctrl;
    logic              dec_illegal;
    logic              sel_on;

`ifndef SINGLE_STEP_EN
    logic step_unused;
    assign step_unused = step;
`endif

    instr_decoder u_dec (
        .opcode  (ir[15:12]),
        .ctrl    (ctrl),
        .illegal (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            pc        <= '0;
            ir        <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == FETCH)
                ir <= imem_rdata;
            if (state == EXECUTE)
                zero_q <= zero;
            if (state == DECODE && dec_illegal)
                illegal_q <= 1'b1;
            // Branch target is taken only when the zero flag captured in EXECUTE was set
            if (state == WRITEBACK)
                pc <= (ctrl.branch && zero_q) ? PC_W'(ir[11:8]) : pc + PC_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        sel_on     = 1'b0;
        W1         = 1'b0;
        W2         = 1'b0;
        W3         = 1'b0;
        ALUCONTROL = 1'b0;
        Branch     = 1'b0;
        MemToReg   = 1'b0;
        memo       = 1'b0;
        regWE      = 1'b0;
        memWE      = 1'b0;

        case (state)
            IDLE:      if (start) state_nxt = FETCH;
            FETCH:     state_nxt = DECODE;
            DECODE:    state_nxt = ctrl.halt ? HALT : EXECUTE;
            EXECUTE:   state_nxt = ctrl.mem_op ? MEMORY : WRITEBACK;
            MEMORY:    state_nxt = WRITEBACK;
`ifdef SINGLE_STEP_EN
            WRITEBACK: state_nxt = STEP_WAIT;
            STEP_WAIT: if (step) state_nxt = FETCH;
`else
            WRITEBACK: state_nxt = FETCH;
`endif
            HALT:      state_nxt = HALT;
            default:   state_nxt = IDLE;
        endcase

        sel_on = (state == DECODE) || (state == EXECUTE) ||
                 (state == MEMORY) || (state == WRITEBACK);
        if (sel_on) begin
            W1         = ctrl.w1;
            W2         = ctrl.w2;
            W3         = ctrl.w3;
            ALUCONTROL = ctrl.alu_ctl;
            Branch     = ctrl.branch;
            MemToReg   = ctrl.mem_to_reg;
            memo       = ctrl.memo;
        end
        regWE = (state == WRITEBACK) && ctrl.reg_wr;
        memWE = (state == MEMORY) && ctrl.mem_wr;
    end

    assign imem_addr = pc;
    assign RDinst    = ir;
    assign busy      = (state != IDLE) && (state != HALT);
    assign halted    = (state == HALT);
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed program plus random instruction stream
// checked cycle by cycle against a per-instruction reference model.
module tb_instr_sequencer;

    localparam int PC_W   = 4;
    localparam int INST_W = 16;

    logic              clk = 1'b0;
    logic              reset_n, start, step, zero;
    logic [INST_W-1:0] imem_rdata;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] RDinst;
    logic W1, W2, W3, ALUCONTROL, Branch, MemToReg, memo;
    logic regWE, memWE, busy, halted, illegal;

    logic [15:0] imem [16];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int m_pc;
    bit m_illegal;
    int start_cyc;
    int last_regwe_cyc;

    instr_sequencer #(.PC_W(PC_W), .INST_W(INST_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .step(step), .zero(zero),
        .imem_rdata(imem_rdata), .imem_addr(imem_addr), .RDinst(RDinst),
        .W1(W1), .W2(W2), .W3(W3), .ALUCONTROL(ALUCONTROL), .Branch(Branch),
        .MemToReg(MemToReg), .memo(memo), .regWE(regWE), .memWE(memWE),
        .busy(busy), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem[imem_addr];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // {W1,W2,W3,ALUCONTROL,Branch,MemToReg,memo} as the instruction set defines them
    function automatic logic [6:0] exp_sel(input logic [3:0] op);
        case (op)
            4'h0:    return 7'b1010011;
            4'h1:    return 7'b0010001;
            4'h2:    return 7'b1000000;
            4'h3:    return 7'b1001000;
            4'h4:    return 7'b1100000;
            4'h5:    return 7'b0000100;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic logic [6:0] got_sel();
        return {W1, W2, W3, ALUCONTROL, Branch, MemToReg, memo};
    endfunction

    task automatic noise();
        start = 1'($urandom_range(0, 1));
`ifndef SINGLE_STEP_EN
        step  = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, "_addr"},   32'(imem_addr), 0);
        check_val({tag, "_ir"},     32'(RDinst), 0);
        check_val({tag, "_sel"},    32'(got_sel()), 0);
        check_val({tag, "_strobe"}, 32'({regWE, memWE}), 0);
        check_val({tag, "_flags"},  32'({busy, halted, illegal}), 0);
    endtask

    // Runs one instruction starting in its FETCH cycle; returns in the next FETCH cycle.
    task automatic exec_one(input int zmode);
        logic [15:0] w;
        logic [3:0]  op;
        bit          is_mem, is_wr, is_ill;
        int          ez;
        w      = imem[m_pc[3:0]];
        op     = w[15:12];
        is_mem = (op == 4'h0) || (op == 4'h1);
        is_wr  = (op == 4'h0) || (op == 4'h2) || (op == 4'h3) || (op == 4'h4);
        is_ill = (op >= 4'h6) && (op <= 4'hE);

        check_val("fetch_addr",   32'(imem_addr), m_pc);
        check_val("fetch_busy",   32'(busy), 1);
        check_val("fetch_sel",    32'(got_sel()), 0);
        check_val("fetch_strobe", 32'({regWE, memWE}), 0);
        noise();
        tick();

        check_val("dec_ir",      32'(RDinst), 32'(w));
        check_val("dec_sel",     32'(got_sel()), 32'(exp_sel(op)));
        check_val("dec_strobe",  32'({regWE, memWE}), 0);
        check_val("dec_illegal", 32'(illegal), 32'(m_illegal));
        if (op == 4'hF) begin
            noise();
            tick();
            check_val("halt_flags",  32'({halted, busy}), 32'(2'b10));
            check_val("halt_sel",    32'(got_sel()), 0);
            check_val("halt_strobe", 32'({regWE, memWE}), 0);
            return;
        end
        m_illegal = m_illegal | is_ill;
        noise();
        tick();

        check_val("ex_sel",     32'(got_sel()), 32'(exp_sel(op)));
        check_val("ex_strobe",  32'({regWE, memWE}), 0);
        check_val("ex_illegal", 32'(illegal), 32'(m_illegal));
        ez   = (zmode == 2) ? int'($urandom_range(0, 1)) : zmode;
        zero = ez[0];
        noise();
        tick();
        zero = 1'($urandom_range(0, 1));

        if (is_mem) begin
            check_val("mem_sel",   32'(got_sel()), 32'(exp_sel(op)));
            check_val("mem_regwe", 32'(regWE), 0);
            check_val("mem_memwe", 32'(memWE), 32'(op == 4'h1));
            noise();
            tick();
        end

        check_val("wb_sel",   32'(got_sel()), 32'(exp_sel(op)));
        check_val("wb_regwe", 32'(regWE), 32'(is_wr));
        check_val("wb_memwe", 32'(memWE), 0);
        check_val("wb_busy",  32'(busy), 1);
        if (regWE) last_regwe_cyc = cyc;
        noise();
        tick();

        if (op == 4'h5 && ez == 1) m_pc = int'(w[11:8]);
        else                       m_pc = (m_pc + 1) % 16;

`ifdef SINGLE_STEP_EN
        begin
            int n;
            n = int'($urandom_range(0, 2));
            for (int i = 0; i <= n; i++) begin
                check_val("stepw_busy",   32'(busy), 1);
                check_val("stepw_sel",    32'(got_sel()), 0);
                check_val("stepw_strobe", 32'({regWE, memWE}), 0);
                step = (i == n);
                tick();
            end
            step = 1'b0;
        end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        zero    = 1'b0;
        last_regwe_cyc = -1;
        for (int i = 0; i < 16; i++) imem[i] = 16'h0000;
        imem[0]  = 16'h4305;
        imem[1]  = 16'h1007;
        imem[2]  = 16'h5A12;
        imem[10] = 16'h5A12;
        imem[11] = 16'h9123;
        imem[12] = 16'h2123;
        imem[13] = 16'h0042;
        imem[14] = 16'h3456;
        imem[15] = 16'h2789;

        #12;
        check_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        check_val("idle_busy", 32'(busy), 0);

        m_pc      = 0;
        m_illegal = 1'b0;
        start_cyc = cyc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        exec_one(2);
        check_val("li_latency", last_regwe_cyc - start_cyc, 4);
        check_val("li_pc",      32'(imem_addr), 1);

        exec_one(2);
        exec_one(1);
        check_val("beq_taken_pc", 32'(imem_addr), 10);
        exec_one(0);
        check_val("beq_not_taken_pc", 32'(imem_addr), 11);
        exec_one(2);
        check_val("illegal_set", 32'(illegal), 1);
        for (int i = 0; i < 4; i++) exec_one(2);
        check_val("wrap_pc", 32'(imem_addr), 0);
        check_val("illegal_sticky", 32'(illegal), 1);

        for (int i = 0; i < 16; i++) begin
            int r;
            logic [3:0] op;
            r  = int'($urandom_range(0, 7));
            op = (r <= 5) ? 4'(r) : (r == 6) ? 4'($urandom_range(6, 14)) : 4'h4;
            imem[i] = {op, 12'($urandom)};
        end
        for (int i = 0; i < 150; i++) exec_one(2);

        imem[m_pc[3:0]] = 16'hF000;
        exec_one(2);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1;
            step  = 1'($urandom_range(0, 1));
            tick();
            check_val("halt_hold_flags",  32'({halted, busy}), 32'(2'b10));
            check_val("halt_hold_addr",   32'(imem_addr), m_pc);
            check_val("halt_hold_strobe", 32'({regWE, memWE, got_sel()}), 0);
        end
        start = 1'b0;
        step  = 1'b0;

        reset_n = 1'b0;
        #1;
        check_reset_vals("halt_reset");
        imem[0] = 16'h1007;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_val("abort_pre_memwe", 32'(memWE), 1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        for (int i = 0; i < 2; i++) begin
            tick();
            check_val("abort_hold_memwe", 32'(memWE), 0);
        end

        imem[0] = 16'h0042;
        m_pc      = 0;
        m_illegal = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        start_cyc = cyc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        exec_one(2);
        check_val("load_latency", last_regwe_cyc - start_cyc, 5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
